// File: rtl/rtc_axil_pkg.sv
// Shared constants for the RTC/TSU register-space arbiter: register map, AXI response codes, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtc_axil_pkg;

    // RTC register block
    localparam logic [31:0] RTC_BASE      = 32'h43C0_0000;
    localparam logic [31:0] RTC_CTRL      = RTC_BASE + 32'h00;
    localparam logic [31:0] RTC_TIME_NS   = RTC_BASE + 32'h04;
    localparam logic [31:0] RTC_TIME_SEC  = RTC_BASE + 32'h08;
    localparam logic [31:0] RTC_ADJPER    = RTC_BASE + 32'h10;
    localparam logic [31:0] RTC_ADJNUM    = RTC_BASE + 32'h14;

    // TSU timestamp queue
    localparam logic [31:0] TSU_BASE      = 32'h43C1_0000;
    localparam logic [31:0] TSU_STATUS    = TSU_BASE + 32'h00;
    localparam logic [31:0] TSU_TS_LO     = TSU_BASE + 32'h04;
    localparam logic [31:0] TSU_TS_HI     = TSU_BASE + 32'h08;
    localparam logic [31:0] TSU_POP       = TSU_BASE + 32'h0C;

    // Control values
    localparam logic [31:0] RTC_CTRL_ENABLE = 32'h0000_0001;
    localparam logic [31:0] RTC_CTRL_ADJ    = 32'h0000_0002;
    localparam logic [31:0] TSU_POP_ONE     = 32'h0000_0001;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Anything other than OKAY is reported as an error, EXOKAY included:
    // these requesters never issue exclusive accesses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/rtc_axil_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or above rr_ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the pick is used.
// Ports: req (request vector), rr_ptr (scan start), grant (winning index), any_req (some bit set).
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               any_req
);

    // Scan from the farthest candidate back toward rr_ptr so the last
    // assignment made is the nearest requester at or after the pointer.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        idx     = 0;
        sel     = '0;
        grant   = '0;
        any_req = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (req[sel]) begin
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/rtc_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master between RTC/TSU requesters, one transaction at a time.
// Latency: req_ready to rsp_valid is 4 cycles inclusive with a zero-wait slave; each slave stall adds a cycle.
// Backpressure: requests are only sampled in IDLE; slave ready/valid stalls hold WRITE/READ with no timeout.
// Ports: req_* command side (one-hot req_ready accept pulse), rsp_* completion side (one-hot rsp_valid,
//        shared rsp_rdata/rsp_err), m_axi_* AXI4-Lite master; s_axi_aclk clock, s_axi_reset sync active-high.
module rtc_axil_arbiter
    import rtc_axil_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_W-1:0]         m_axi_wdata,
    output logic [DATA_W/8-1:0]       m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_W / 8;

    arb_state_t         state_q;
    arb_state_t         state_d;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   pick_grant;
    logic               pick_any;

    logic [PTR_W-1:0]   grant_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         resp_q;

    // Sticky handshake status for the in-flight transaction
    logic               aw_done;
    logic               w_done;
    logic               b_done;
    logic               ar_done;

    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               ar_hs;
    logic               r_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .grant   (pick_grant),
        .any_req (pick_any)
    );

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;
    assign b_hs  = m_axi_bvalid  & m_axi_bready;
    assign ar_hs = m_axi_arvalid & m_axi_arready;
    assign r_hs  = m_axi_rvalid  & m_axi_rready;

    // Address/data come straight from the command registers, so they are
    // stable for the whole transaction and zero out of reset.
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    // All byte lanes are written; gating with wvalid keeps the bus quiet when idle.
    assign m_axi_wstrb  = {STRB_W{m_axi_wvalid}};

    // ---------------------------------------------------------------- state register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = req_write[pick_grant] ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // Handshakes landing this cycle count, so a response arriving
                // together with the last aw/w handshake exits immediately.
                if ((aw_done | aw_hs) & (w_done | w_hs) & (b_done | b_hs)) begin
                    state_d = ST_RESP;
                end
            end
            ST_READ: begin
                if (r_hs) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready = NUM_REQ'(1) << pick_grant;
                end
            end
            ST_WRITE: begin
                m_axi_awvalid = ~aw_done;
                m_axi_wvalid  = ~w_done;
                m_axi_bready  = 1'b1;
            end
            ST_READ: begin
                m_axi_arvalid = ~ar_done;
                m_axi_rready  = 1'b1;
            end
            ST_RESP: begin
                rsp_valid = NUM_REQ'(1) << grant_q;
                rsp_rdata = write_q ? '0 : rdata_q;
                rsp_err   = resp_is_err(resp_q);
            end
            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_reset) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= AXI_RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            b_done  <= 1'b0;
            ar_done <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    b_done  <= 1'b0;
                    ar_done <= 1'b0;
                    if (pick_any) begin
                        grant_q <= pick_grant;
                        write_q <= req_write[pick_grant];
                        addr_q  <= req_addr[int'(pick_grant)*ADDR_W +: ADDR_W];
                        wdata_q <= req_wdata[int'(pick_grant)*DATA_W +: DATA_W];
                    end
                end
                ST_WRITE: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        b_done <= 1'b1;
                        resp_q <= m_axi_bresp;
                    end
                end
                ST_READ: begin
                    if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                    if (r_hs) begin
                        rdata_q <= m_axi_rdata;
                        resp_q  <= m_axi_rresp;
                    end
                end
                ST_RESP: begin
                    rr_ptr <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_axil_arbiter.sv
// Directed bench for rtc_axil_arbiter with a small configurable AXI4-Lite slave model.
// Latency: n/a.
// Backpressure: slave readiness and response delays are set per test.
module tb_rtc_axil_arbiter;
    import rtc_axil_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      s_axi_aclk = 1'b0;
    logic                      s_axi_reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         m_axi_awaddr;
    logic                      m_axi_awvalid;
    logic                      m_axi_awready;
    logic [DATA_W-1:0]         m_axi_wdata;
    logic [DATA_W/8-1:0]       m_axi_wstrb;
    logic                      m_axi_wvalid;
    logic                      m_axi_wready;
    logic [1:0]                m_axi_bresp;
    logic                      m_axi_bvalid;
    logic                      m_axi_bready;
    logic [ADDR_W-1:0]         m_axi_araddr;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;
    logic [DATA_W-1:0]         m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    always #5 s_axi_aclk = ~s_axi_aclk;

    rtc_axil_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_reset   (s_axi_reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------ slave model
    int          aw_dly = 0, w_dly = 0, b_dly = 1, ar_dly = 0, r_dly = 1;
    bit          b_early = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [1:0]  cfg_bresp = 2'b00;

    bit aw_dm, w_dm, ar_dm, p_aw, p_w, p_b, p_ar, p_r;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        aw_dm = 0; w_dm = 0; ar_dm = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        forever begin
            @(negedge s_axi_aclk);
            // account for handshakes taken at the posedge just gone
            if (p_aw) aw_dm = 1;
            if (p_w)  w_dm = 1;
            if (p_ar) ar_dm = 1;
            if (p_b) begin aw_dm = 0; w_dm = 0; aw_wait = 0; w_wait = 0; b_wait = 0; end
            if (p_r) begin ar_dm = 0; ar_wait = 0; r_wait = 0; end
            if (s_axi_reset) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
                aw_dm = 0; w_dm = 0; ar_dm = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
            end else begin
                m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
                if (m_axi_awvalid && !m_axi_awready) aw_wait++;
                m_axi_wready = m_axi_wvalid && (w_wait >= w_dly);
                if (m_axi_wvalid && !m_axi_wready) w_wait++;
                if (b_early) begin
                    m_axi_bvalid = (aw_dm || (m_axi_awvalid && m_axi_awready)) &&
                                   (w_dm  || (m_axi_wvalid  && m_axi_wready));
                end else begin
                    if (aw_dm && w_dm) b_wait++;
                    m_axi_bvalid = aw_dm && w_dm && (b_wait >= b_dly);
                end
                m_axi_bresp = m_axi_bvalid ? cfg_bresp : 2'b00;
                m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
                if (m_axi_arvalid && !m_axi_arready) ar_wait++;
                if (ar_dm) r_wait++;
                m_axi_rvalid = ar_dm && (r_wait >= r_dly);
                m_axi_rdata  = m_axi_rvalid ? cfg_rdata : 32'h0;
                m_axi_rresp  = m_axi_rvalid ? cfg_rresp : 2'b00;
                p_aw = m_axi_awvalid && m_axi_awready;
                p_w  = m_axi_wvalid  && m_axi_wready;
                p_b  = m_axi_bvalid  && m_axi_bready;
                p_ar = m_axi_arvalid && m_axi_arready;
                p_r  = m_axi_rvalid  && m_axi_rready;
            end
        end
    end

    // ------------------------------------------------------------ monitor
    int                 aw_fall = 0, w_fall = 0, rsp_cnt = 0, viol = 0;
    bit                 busy = 0, prev_aw = 0, prev_w = 0;
    logic [31:0]        mon_awaddr = '0, mon_wdata = '0, mon_araddr = '0;
    logic [NUM_REQ-1:0] grants[$];

    initial begin
        forever begin
            @(negedge s_axi_aclk);
            if (s_axi_reset) begin
                busy = 0; prev_aw = 0; prev_w = 0;
            end else begin
                if (prev_aw && !m_axi_awvalid) aw_fall++;
                if (prev_w && !m_axi_wvalid) w_fall++;
                prev_aw = m_axi_awvalid;
                prev_w  = m_axi_wvalid;
                if (m_axi_awvalid) mon_awaddr = m_axi_awaddr;
                if (m_axi_wvalid)  mon_wdata  = m_axi_wdata;
                if (m_axi_arvalid) mon_araddr = m_axi_araddr;
                if (|req_ready) begin
                    if (busy) viol++;
                    busy = 1;
                    grants.push_back(req_ready);
                end
                if (|rsp_valid) begin
                    busy = 0;
                    rsp_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    task automatic issue(input string tag, input int idx, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit wait_rsp,
                         output logic [NUM_REQ-1:0] rsp_v, output logic [31:0] rdat,
                         output logic err, output int lat);
        bit got;
        rsp_v = '0; rdat = '0; err = 1'b0; lat = 0;
        @(posedge s_axi_aclk); #1;
        req_valid[idx] = 1'b1;
        req_write[idx] = wr;
        req_addr[idx*ADDR_W +: ADDR_W]  = addr;
        req_wdata[idx*DATA_W +: DATA_W] = data;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge s_axi_aclk);
            if (req_ready[idx]) got = 1;
        end
        check_eq({tag, " accept"}, 64'(got), 64'd1);
        @(posedge s_axi_aclk); #1;
        req_valid[idx] = 1'b0;
        if (wait_rsp) begin
            got = 0;
            lat = 1;
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge s_axi_aclk);
                lat++;
                if (|rsp_valid) begin
                    got = 1; rsp_v = rsp_valid; rdat = rsp_rdata; err = rsp_err;
                end
            end
            check_eq({tag, " response"}, 64'(got), 64'd1);
        end
    endtask

    logic [NUM_REQ-1:0] rv;
    logic [31:0]        rd;
    logic               er;
    int                 lat;
    int                 base_r;
    int                 base_g;
    bit                 done;

    initial begin
        // ---- reset state
        repeat (3) @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        check_eq("reset ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                m_axi_rready, req_ready, rsp_valid, rsp_err}, 64'd0);
        check_eq("reset addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
        check_eq("reset data", {m_axi_wdata, rsp_rdata}, 64'd0);
        @(posedge s_axi_aclk); #1;
        s_axi_reset = 1'b0;
        @(negedge s_axi_aclk);
        check_eq("idle state", 64'(dut.state_q), 64'(ST_IDLE));

        // ---- single read, zero-wait slave
        cfg_rdata = 32'h0000_1234; cfg_rresp = AXI_RESP_OKAY;
        issue("rd0", 0, 1'b0, 32'h43C0_0010, 32'h0, 1'b1, rv, rd, er, lat);
        check_eq("rd0 rsp_valid", 64'(rv), 64'h1);
        check_eq("rd0 rdata", 64'(rd), 64'h1234);
        check_eq("rd0 err", 64'(er), 64'd0);
        check_eq("rd0 latency", 64'(lat), 64'd4);
        check_eq("rd0 araddr", 64'(mon_araddr), 64'h43C0_0010);

        // ---- skewed write from requester 1
        aw_dly = 0; w_dly = 3; b_dly = 2; cfg_bresp = AXI_RESP_OKAY;
        aw_fall = 0; w_fall = 0; base_r = rsp_cnt;
        issue("wr1", 1, 1'b1, 32'h43C0_0000, 32'h0000_0010, 1'b1, rv, rd, er, lat);
        check_eq("wr1 rsp_valid", 64'(rv), 64'h2);
        check_eq("wr1 rdata", 64'(rd), 64'h0);
        check_eq("wr1 err", 64'(er), 64'd0);
        check_eq("wr1 latency", 64'(lat), 64'd8);
        repeat (5) @(negedge s_axi_aclk); #1;
        check_eq("wr1 awvalid drops", 64'(aw_fall), 64'd1);
        check_eq("wr1 wvalid drops", 64'(w_fall), 64'd1);
        check_eq("wr1 awaddr", 64'(mon_awaddr), 64'h43C0_0000);
        check_eq("wr1 wdata", 64'(mon_wdata), 64'h10);
        check_eq("wr1 rsp count", 64'(rsp_cnt - base_r), 64'd1);
        w_dly = 0; b_dly = 1;

        // ---- contention: both requesters hold valid for six grants
        cfg_rdata = 32'hCAFE_0001;
        @(posedge s_axi_aclk); #1;
        base_g = grants.size(); base_r = rsp_cnt;
        req_write = '0;
        req_addr  = {RTC_TIME_NS, TSU_TS_LO};
        req_valid = 2'b11;
        done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge s_axi_aclk); #1;
            if (grants.size() >= base_g + 6) done = 1;
        end
        check_eq("contention grants", 64'(done), 64'd1);
        @(posedge s_axi_aclk); #1;
        req_valid = '0;
        repeat (8) @(negedge s_axi_aclk); #1;
        for (int i = 0; i < 6; i++) begin
            logic [NUM_REQ-1:0] g;
            g = (base_g + i < grants.size()) ? grants[base_g + i] : '0;
            check_eq($sformatf("grant %0d", i), 64'(g), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        check_eq("contention extra grants", 64'(grants.size() - base_g), 64'd6);
        check_eq("contention rsp count", 64'(rsp_cnt - base_r), 64'd6);
        check_eq("ready while busy", 64'(viol), 64'd0);

        // ---- error response then OKAY
        cfg_rresp = AXI_RESP_SLVERR; cfg_rdata = 32'hDEAD_0000;
        issue("err1", 1, 1'b0, TSU_STATUS, 32'h0, 1'b1, rv, rd, er, lat);
        check_eq("err1 rsp_valid", 64'(rv), 64'h2);
        check_eq("err1 err", 64'(er), 64'd1);
        cfg_rresp = AXI_RESP_OKAY; cfg_rdata = 32'h0000_5A5A;
        issue("ok0", 0, 1'b0, RTC_ADJPER, 32'h0, 1'b1, rv, rd, er, lat);
        check_eq("ok0 rsp_valid", 64'(rv), 64'h1);
        check_eq("ok0 err", 64'(er), 64'd0);
        check_eq("ok0 rdata", 64'(rd), 64'h5A5A);

        // ---- reset in the middle of a stalled READ (rr_ptr is 1 here)
        ar_dly = 20;
        issue("rst1", 1, 1'b0, TSU_TS_HI, 32'h0, 1'b0, rv, rd, er, lat);
        @(negedge s_axi_aclk);
        check_eq("arvalid before reset", 64'(m_axi_arvalid), 64'd1);
        @(posedge s_axi_aclk); #1;
        s_axi_reset = 1'b1;
        @(posedge s_axi_aclk); #1;
        s_axi_reset = 1'b0;
        @(negedge s_axi_aclk);
        check_eq("post-reset ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                     m_axi_rready, req_ready, rsp_valid, rsp_err}, 64'd0);
        check_eq("post-reset addr", {m_axi_awaddr, m_axi_araddr}, 64'd0);
        check_eq("post-reset data", {m_axi_wdata, rsp_rdata}, 64'd0);
        check_eq("post-reset state", 64'(dut.state_q), 64'(ST_IDLE));
        check_eq("post-reset rr_ptr", 64'(dut.rr_ptr), 64'd0);
        ar_dly = 0; cfg_rdata = 32'h0000_0777;
        issue("after rst", 1, 1'b0, TSU_TS_HI, 32'h0, 1'b1, rv, rd, er, lat);
        check_eq("after rst rsp_valid", 64'(rv), 64'h2);
        check_eq("after rst rdata", 64'(rd), 64'h777);
        check_eq("after rst latency", 64'(lat), 64'd4);

        // ---- bvalid together with the final aw/w handshake
        aw_dly = 0; w_dly = 2; b_early = 1; cfg_bresp = AXI_RESP_OKAY;
        aw_fall = 0; w_fall = 0; base_r = rsp_cnt;
        issue("wrb", 0, 1'b1, RTC_ADJNUM, 32'h0000_00AB, 1'b1, rv, rd, er, lat);
        check_eq("wrb rsp_valid", 64'(rv), 64'h1);
        check_eq("wrb err", 64'(er), 64'd0);
        check_eq("wrb latency", 64'(lat), 64'd5);
        repeat (6) @(negedge s_axi_aclk); #1;
        check_eq("wrb rsp count", 64'(rsp_cnt - base_r), 64'd1);
        check_eq("wrb awvalid drops", 64'(aw_fall), 64'd1);
        check_eq("wrb wvalid drops", 64'(w_fall), 64'd1);
        check_eq("wrb wdata", 64'(mon_wdata), 64'hAB);
        b_early = 0; w_dly = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
